// File: rtl/port0_rr_arb.sv
// Round-robin merge of two packet sources onto port_0. Each input is buffered
// per flit and per packet, and a packet is forwarded only once it is complete.
//   state | meaning
//   IDLE  | wait for out_data_ready plus a fully buffered packet, then grant
//   SEND  | stream the granted packet one flit per cycle up to its tail
//   VAL   | emit the packet-good strobe and bump the per-input packet count
module port0_rr_arb #(
  parameter int DEPTH_LOG2     = 8,
  parameter int MAX_PKT_FLITS  = 96,
  parameter int PKT_DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in0_data,
  input  logic         in0_data_wr,
  input  logic         in0_data_valid,
  input  logic         in0_data_valid_wr,
  output logic         in0_data_ready,
  input  logic [133:0] in1_data,
  input  logic         in1_data_wr,
  input  logic         in1_data_valid,
  input  logic         in1_data_valid_wr,
  output logic         in1_data_ready,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  input  logic         out_data_ready,
  output logic [1:0]   ovf,
  output logic [31:0]  pkt_cnt_0,
  output logic [31:0]  pkt_cnt_1
);
  localparam int W      = 134;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PDEPTH = 1 << PKT_DEPTH_LOG2;
  localparam int FCW    = DEPTH_LOG2 + 1;
  localparam int PCW    = PKT_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SEND, VAL} state_t;

  logic [1:0][W-1:0] din;
  logic [1:0]        dwr, vin, vwr;

  logic [W-1:0]                    fmem [2][DEPTH];
  logic [1:0][DEPTH_LOG2-1:0]      fwp, frp;
  logic [1:0][FCW-1:0]             fcnt, fcnt_nxt;
  logic [1:0][PDEPTH-1:0]          pmem;
  logic [1:0][PKT_DEPTH_LOG2-1:0]  pwp, prp;
  logic [1:0][PCW-1:0]             pcnt, pcnt_nxt;
  logic [1:0]                      fwr, fpop, pwr, ppop, elig, ready_nxt, in_ready;

  state_t       state;
  logic         gnt, rr, pick, vbit, is_tail;
  logic [W-1:0] cur_flit;

  assign din = {in1_data, in0_data};
  assign dwr = {in1_data_wr, in0_data_wr};
  assign vin = {in1_data_valid, in0_data_valid};
  assign vwr = {in1_data_valid_wr, in0_data_valid_wr};
  assign in0_data_ready = in_ready[0];
  assign in1_data_ready = in_ready[1];

  // Ready looks at next-state occupancy so it settles one cycle after a push/pop.
  always_comb begin
    cur_flit = fmem[gnt][frp[gnt]];
    is_tail  = (cur_flit[W-1:W-2] == 2'b10);
    for (int n = 0; n < 2; n++) begin
      fwr[n]       = dwr[n] && (fcnt[n] != FCW'(DEPTH));
      pwr[n]       = vwr[n] && (pcnt[n] != PCW'(PDEPTH));
      fpop[n]      = (state == SEND) && (gnt == 1'(n)) && (fcnt[n] != '0);
      ppop[n]      = fpop[n] && is_tail && (pcnt[n] != '0);
      fcnt_nxt[n]  = fcnt[n] + FCW'(fwr[n]) - FCW'(fpop[n]);
      pcnt_nxt[n]  = pcnt[n] + PCW'(pwr[n]) - PCW'(ppop[n]);
      ready_nxt[n] = (fcnt_nxt[n] <= FCW'(DEPTH - MAX_PKT_FLITS)) &&
                     (pcnt_nxt[n] != PCW'(PDEPTH));
      elig[n]      = (pcnt[n] != '0);
    end
    pick = (elig == 2'b11) ? ~rr : elig[1];
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (fwr[n]) fmem[n][fwp[n]] <= din[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp      <= '0;
      frp      <= '0;
      fcnt     <= '0;
      pmem     <= '0;
      pwp      <= '0;
      prp      <= '0;
      pcnt     <= '0;
      in_ready <= '0;
      ovf      <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (fwr[n]) fwp[n] <= fwp[n] + 1'b1;
        if (fpop[n]) frp[n] <= frp[n] + 1'b1;
        if (pwr[n]) begin
          pmem[n][pwp[n]] <= vin[n];
          pwp[n]          <= pwp[n] + 1'b1;
        end
        if (ppop[n]) prp[n] <= prp[n] + 1'b1;
        fcnt[n]     <= fcnt_nxt[n];
        pcnt[n]     <= pcnt_nxt[n];
        in_ready[n] <= ready_nxt[n];
        if (dwr[n] && !fwr[n]) ovf[n] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      gnt               <= 1'b0;
      rr                <= 1'b1;
      vbit              <= 1'b0;
      out_data          <= '0;
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      pkt_cnt_0         <= '0;
      pkt_cnt_1         <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_data_valid_wr <= 1'b0;
          out_data_valid    <= 1'b0;
          if (out_data_ready && (elig != 2'b00)) begin
            gnt   <= pick;
            rr    <= pick;
            state <= SEND;
          end
        end
        SEND: begin
          out_data_wr <= fpop[gnt];
          if (fpop[gnt]) begin
            out_data <= cur_flit;
            if (is_tail) begin
              vbit  <= pmem[gnt][prp[gnt]];
              state <= VAL;
            end
          end
        end
        VAL: begin
          out_data_wr       <= 1'b0;
          out_data_valid_wr <= 1'b1;
          out_data_valid    <= vbit;
          if (gnt) pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
          else     pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port0_rr_arb.sv
// Self-checking bench for port0_rr_arb: scoreboard monitor on port_0, a table
// of single-source packets, and hand sequences for timing and corner cases.
module tb_port0_rr_arb;
  localparam int W = 134;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] in0_data = '0, in1_data = '0;
  logic         in0_data_wr = 1'b0, in0_data_valid = 1'b0, in0_data_valid_wr = 1'b0;
  logic         in1_data_wr = 1'b0, in1_data_valid = 1'b0, in1_data_valid_wr = 1'b0;
  logic         in0_data_ready, in1_data_ready;
  logic [W-1:0] out_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic         out_data_ready = 1'b0;
  logic [1:0]   ovf;
  logic [31:0]  pkt_cnt_0, pkt_cnt_1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic vwr; logic [W-1:0] data; logic vld; } ev_t;
  ev_t sb[$];
  ev_t mon_e;

  typedef struct { int src; int len; logic vld; int cnt0; int cnt1; } vec_t;
  vec_t vt[6];

  logic [1:0] sp_pat [8];
  logic [1:0] fp[$];

  port0_rr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_data_wr(in0_data_wr), .in0_data_valid(in0_data_valid),
    .in0_data_valid_wr(in0_data_valid_wr), .in0_data_ready(in0_data_ready),
    .in1_data(in1_data), .in1_data_wr(in1_data_wr), .in1_data_valid(in1_data_valid),
    .in1_data_valid_wr(in1_data_valid_wr), .in1_data_ready(in1_data_ready),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_data_valid(out_data_valid),
    .out_data_valid_wr(out_data_valid_wr), .out_data_ready(out_data_ready),
    .ovf(ovf), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk_flit(int src, int id, int idx, int len);
    logic [1:0]  t;
    logic [31:0] h;
    t = (idx == 0) ? 2'b01 : (idx == len - 1) ? 2'b10 : 2'b11;
    h = (32'(id) * 32'h9E3779B1) ^ 32'(idx) ^ (32'(src) << 28);
    return {t, 4'(src), 16'(id), 16'(idx), h, ~h, h ^ 32'hA5A5_5A5A};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (out_data_wr || out_data_valid_wr)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got wr=%0b valid_wr=%0b data=0x%0h, required no output",
                 out_data_wr, out_data_valid_wr, out_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_kind", W'(out_data_valid_wr), W'(mon_e.vwr));
        if (mon_e.vwr) check("sb_valid", W'(out_data_valid), W'(mon_e.vld));
        else           check("sb_data", out_data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_flit(input int src, input logic [W-1:0] d, input logic vw, input logic vld);
    if (src == 0) begin
      in0_data = d; in0_data_wr = 1'b1; in0_data_valid_wr = vw; in0_data_valid = vld;
    end else begin
      in1_data = d; in1_data_wr = 1'b1; in1_data_valid_wr = vw; in1_data_valid = vld;
    end
    tick();
    in0_data_wr = 1'b0; in0_data_valid_wr = 1'b0;
    in1_data_wr = 1'b0; in1_data_valid_wr = 1'b0;
  endtask

  task automatic push_exp(input int src, input int id, input int len, input logic vld);
    for (int i = 0; i < len; i++) sb.push_back('{1'b0, mk_flit(src, id, i, len), 1'b0});
    sb.push_back('{1'b1, {W{1'b0}}, vld});
  endtask

  task automatic send_pkt(input int src, input int id, input int len, input logic vld, input bit push);
    if (push) push_exp(src, id, len, vld);
    for (int i = 0; i < len; i++) wr_flit(src, mk_flit(src, id, i, len), (i == len - 1), vld);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, sb.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_data_ready = 1'b0;
    in0_data_wr = 1'b0; in0_data_valid_wr = 1'b0;
    in1_data_wr = 1'b0; in1_data_valid_wr = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int   cnt;
    bit   found;
    logic prev;
    logic [W-1:0] b_head;

    vt[0] = '{src: 0, len: 4, vld: 1'b1, cnt0: 2, cnt1: 0};
    vt[1] = '{src: 1, len: 2, vld: 1'b0, cnt0: 2, cnt1: 1};
    vt[2] = '{src: 0, len: 3, vld: 1'b1, cnt0: 3, cnt1: 1};
    vt[3] = '{src: 1, len: 5, vld: 1'b1, cnt0: 3, cnt1: 2};
    vt[4] = '{src: 0, len: 2, vld: 1'b0, cnt0: 4, cnt1: 2};
    vt[5] = '{src: 1, len: 8, vld: 1'b1, cnt0: 4, cnt1: 3};
    sp_pat = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", W'({out_data_wr, out_data_valid_wr, out_data_valid,
                          in0_data_ready, in1_data_ready, ovf}), W'(0));
    check("rst_data", out_data, W'(0));
    check("rst_cnt", W'({pkt_cnt_0, pkt_cnt_1}), W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("rst_ready", W'({in1_data_ready, in0_data_ready}), W'(2'b11));

    // Single packet: latency and back-to-back flit timing
    out_data_ready = 1'b1;
    send_pkt(0, 1, 4, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("single_cyc%0d", i), W'({out_data_wr, out_data_valid_wr}), W'(sp_pat[i]));
    end
    wait_drain("single", 20);
    check("single_cnt0", W'(pkt_cnt_0), W'(1));

    // Table of packets, one source at a time
    for (int i = 0; i < 6; i++) begin
      send_pkt(vt[i].src, 100 + i, vt[i].len, vt[i].vld, 1'b1);
      wait_drain($sformatf("tbl%0d_drain", i), 40);
      check($sformatf("tbl%0d_cnt0", i), W'(pkt_cnt_0), W'(vt[i].cnt0));
      check($sformatf("tbl%0d_cnt1", i), W'(pkt_cnt_1), W'(vt[i].cnt1));
    end

    // Drop out_data_ready mid-packet: packet still completes
    send_pkt(1, 40, 6, 1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_data_wr) begin
        found = 1'b1;
        break;
      end
    end
    out_data_ready = 1'b0;
    check("bp_mid_seen", W'(found), W'(1));
    wait_drain("bp_mid", 30);
    check("bp_mid_cnt1", W'(pkt_cnt_1), W'(4));

    // Fairness with backpressure release
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_pkt(0, 10 + k, 2, 1'b1, 1'b0);
      send_pkt(1, 20 + k, 2, 1'b1, 1'b0);
    end
    repeat (4) begin
      @(negedge clk);
      check("bp_hold", W'({out_data_wr, out_data_valid_wr}), W'(0));
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 10 + k, 2, 1'b1);
      push_exp(1, 20 + k, 2, 1'b1);
    end
    fp.delete();
    fp.push_back(2'b00);
    fp.push_back(2'b00);
    for (int k = 0; k < 6; k++) begin
      fp.push_back(2'b10); fp.push_back(2'b10); fp.push_back(2'b01); fp.push_back(2'b00);
    end
    tick();
    out_data_ready = 1'b1;
    for (int i = 0; i < fp.size(); i++) begin
      @(negedge clk);
      check($sformatf("fair_cyc%0d", i), W'({out_data_wr, out_data_valid_wr}), W'(fp[i]));
    end
    wait_drain("fair", 20);
    check("fair_cnt", W'({pkt_cnt_0, pkt_cnt_1}), W'({32'd3, 32'd3}));

    // Ready threshold on input 1
    do_reset();
    send_pkt(1, 1, 2, 1'b1, 1'b1);
    send_pkt(1, 2, 3, 1'b1, 1'b1);
    for (int i = 0; i < 158; i++) begin
      wr_flit(1, mk_flit(1, 99, i, 1000), 1'b0, 1'b0);
      cnt = 5 + i + 1;
      if (cnt == 160) check("thr_ready_160", W'(in1_data_ready), W'(1));
      if (cnt == 161) check("thr_ready_161", W'(in1_data_ready), W'(0));
      if (cnt == 163) check("thr_ready_163", W'(in1_data_ready), W'(0));
    end
    b_head = mk_flit(1, 2, 0, 3);
    out_data_ready = 1'b1;
    prev = in1_data_ready;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_data_wr && out_data == b_head) begin
        found = 1'b1;
        break;
      end
      prev = in1_data_ready;
    end
    check("thr_bhead_seen", W'(found), W'(1));
    check("thr_ready_before", W'(prev), W'(0));
    check("thr_ready_after", W'(in1_data_ready), W'(1));
    wait_drain("thr", 30);

    // Overflow on input 0
    do_reset();
    for (int p = 0; p < 16; p++) send_pkt(0, p, 16, 1'b1, 1'b1);
    check("ovf_before", W'(ovf), W'(0));
    wr_flit(0, mk_flit(0, 16, 0, 16), 1'b0, 1'b0);
    check("ovf_set", W'(ovf), W'(2'b01));
    check("ovf_ready", W'(in0_data_ready), W'(0));
    out_data_ready = 1'b1;
    wait_drain("ovf_drain", 500);
    check("ovf_cnt0", W'(pkt_cnt_0), W'(16));
    check("ovf_sticky", W'(ovf), W'(2'b01));
    repeat (10) @(negedge clk);

    // Async reset during the third flit of a 6-flit send
    do_reset();
    out_data_ready = 1'b1;
    send_pkt(0, 30, 6, 1'b1, 1'b1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_data_wr) cnt++;
      if (cnt == 3) break;
    end
    check("arst_third_seen", W'(cnt), W'(3));
    #1 rst_n = 1'b0;
    #1;
    check("arst_ctrl", W'({out_data_wr, out_data_valid_wr, out_data_valid,
                           in0_data_ready, in1_data_ready, ovf}), W'(0));
    check("arst_data", out_data, W'(0));
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("arst_ready", W'({in1_data_ready, in0_data_ready}), W'(2'b11));
    check("arst_cnt", W'({pkt_cnt_0, pkt_cnt_1}), W'(0));
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
